// File: rtl/demux_stream_1n_if.sv
// rtl/demux_stream_1n_if.sv - stream, steering and per-channel output bundle for demux_stream_1n
interface demux_stream_1n_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                         mode;
    logic [SEL_W-1:0]             sel;
    logic                         rr_restart;
    logic                         in_valid;
    logic [DATA_WIDTH-1:0]        in_data;
    logic                         in_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH-1:0]            out_ready;
    logic [SEL_W-1:0]             cur_ch;
    logic                         sel_err;

    modport master (
        output mode, sel, rr_restart, in_valid, in_data, out_ready,
        input  in_ready, out_data, out_valid, cur_ch, sel_err
    );

    modport slave (
        input  mode, sel, rr_restart, in_valid, in_data, out_ready,
        output in_ready, out_data, out_valid, cur_ch, sel_err
    );
endinterface

// File: rtl/demux_stream_1n.sv
// rtl/demux_stream_1n.sv - registered 1:N stream demux, explicit select or burst round-robin
// DEMUX_ZERO_IDLE_EN: invalid lanes read 0 and drained lanes are cleared.
module demux_stream_1n #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    demux_stream_1n_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [SEL_W:0]   NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] lane_q [NUM_CH];
    logic [NUM_CH-1:0]     valid_q;
    logic [SEL_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      beat_q;
    logic                  err_q;

    logic [SEL_W-1:0]      target;
    logic                  legal;
    logic                  target_free;
    logic                  ready;
    logic                  accept;
    logic                  drop;
    logic [NUM_CH-1:0]     free;
    logic [NUM_CH-1:0]     wr_en;

    // in_ready must not look at in_valid, so it is built from steering and channel state only
    always_comb begin
        target      = bus.mode ? ptr_q : bus.sel;
        legal       = ({1'b0, target} < NUM_CH_EXT);
        free        = ~valid_q | bus.out_ready;
        target_free = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (target == SEL_W'(k)) begin
                target_free = free[k];
            end
        end
        ready  = legal ? target_free : 1'b1;
        accept = bus.in_valid && ready && legal;
        drop   = bus.in_valid && !legal;
        wr_en  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            wr_en[k] = accept && (target == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                lane_q[k] <= '0;
            end
            valid_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= drop;
            // a write wins over a drain on the same lane, giving back-to-back throughput
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) begin
                    lane_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (valid_q[k] && bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
`ifdef DEMUX_ZERO_IDLE_EN
                    lane_q[k]  <= '0;
`endif
                end
            end
            if (bus.rr_restart) begin
                ptr_q  <= '0;
                beat_q <= '0;
            end else if (accept && bus.mode) begin
                if (beat_q == CNT_LAST) begin
                    beat_q <= '0;
                    ptr_q  <= (ptr_q == CH_LAST) ? '0 : ptr_q + SEL_W'(1);
                end else begin
                    beat_q <= beat_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.cur_ch    = ptr_q;
    assign bus.sel_err   = err_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
`ifdef DEMUX_ZERO_IDLE_EN
        assign bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k] & {DATA_WIDTH{valid_q[k]}};
`else
        assign bus.out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
`endif
    end
endmodule

// File: doc/demux_stream_1n.md
Name: demux_stream_1n

Overview:
- Registered, handshaked 1:N stream distributor, parametrised in data width, channel count and burst length.
- Takes one valid/ready input stream and steers each accepted beat into one of NUM_CH output channel registers.
- Steering is either explicit (per-beat select) or automatic round-robin in bursts.
- Sits between the feature/weight fetch path and the PE rows of the CNN array, so each row is loaded from a single shared stream.

Parameters:
- DATA_WIDTH, 8, bits per data beat.
- NUM_CH, 4, number of output channels; legal range 2..64, not necessarily a power of two.
- BURST_LEN, 1, beats delivered to a channel before the round-robin pointer advances; legal range 1..256.
- SEL_W, $clog2(NUM_CH), derived localparam; width of sel and cur_ch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  target channel in mode 0; ignored in mode 1.
- rr_restart  in  1  returns the round-robin pointer and beat counter to 0.
- in_valid  in  1  input beat valid.
- in_data  in  DATA_WIDTH  input beat.
- in_ready  out  1  input may be accepted this cycle.
- out_data  out  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  NUM_CH  per-channel valid.
- out_ready  in  NUM_CH  per-channel consumer ready.
- cur_ch  out  SEL_W  current round-robin pointer.
- sel_err  out  1  one-cycle pulse when a beat is dropped for an out-of-range sel.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - reset is synchronous and active-high and overrides every other input.
  - Reset values: out_valid=0, out_data=0, cur_ch=0, beat counter=0, sel_err=0.
- Target channel T:
  - Mode 0: T = sel.
  - Mode 1: T = cur_ch.
- Per-channel storage:
  - Each channel has a one-entry register plus a valid bit.
  - The channel is "free" when out_valid[T]==0 or out_ready[T]==1.
- Input handshake:
  - in_ready = free(T) when T < NUM_CH.
  - in_ready = 1 when mode==0 and sel >= NUM_CH; the beat is then dropped.
  - in_ready is combinational from mode, sel, cur_ch, out_valid and out_ready only. It never depends on in_valid.
- Accept (in_valid && in_ready, T legal):
  - Next cycle: out_data lane T <= in_data, out_valid[T] <= 1.
  - Latency is exactly 1 cycle from input accept to out_valid.
- Drain:
  - When out_valid[k] && out_ready[k] and channel k is not being written this cycle, out_valid[k] <= 0.
  - Simultaneous drain and write on the same channel: out_valid stays 1 and the data updates. This gives full throughput with no bubble.
- Non-target lanes hold their data and valid. They are never zeroed, unless the optional feature below is compiled in.
- Round-robin (mode 1):
  - Each accepted beat increments the beat counter.
  - When the counter reaches BURST_LEN-1, it returns to 0 and cur_ch advances by 1.
  - cur_ch wraps from NUM_CH-1 to 0; this is correct for non-power-of-two NUM_CH.
  - Stalled or invalid cycles change nothing.
- rr_restart:
  - Sets cur_ch=0 and the beat counter to 0 next cycle.
  - If it coincides with an accept, the beat still goes to the pre-restart cur_ch, and then restart wins.
  - Allowed in either mode.
  - Does not touch out_valid or out_data.
- Mode 0 leaves cur_ch and the beat counter frozen. Switching mode mid-burst resumes the round-robin where it left off.
- Out-of-range sel (mode 0, sel >= NUM_CH) with in_valid:
  - The beat is consumed and discarded.
  - sel_err = 1 for exactly the following cycle.
  - No channel state changes.
- Reset asserted mid-burst discards all held beats and the pointer state. in_ready is evaluated from the reset state on the next cycle.

Optional Feature:
- Macro: DEMUX_ZERO_IDLE_EN.
- Defined:
  - Each out_data lane is ANDed with its out_valid bit, so invalid lanes read 0. This matches the legacy zero-fill demux behaviour for consumers that ignore valid.
  - Also, a drained lane's register is cleared to 0.
- Undefined: lanes hold their last written value; consumers must qualify by out_valid.
- Handshake, latency and pointer behaviour are identical either way.

Test Plan:
- Reset, then mode 0, NUM_CH=4, all out_ready=1, send sel=2 data 0xA5 → next cycle out_valid=4'b0100, lane2=0xA5, in_ready stays 1. Follow with sel=0 data 0x3C → out_valid=4'b0001, lane0=0x3C.
- Mode 1, BURST_LEN=2, out_ready all 1, stream 0x01..0x08 → lane0 gets 0x01,0x02; lane1 gets 0x03,0x04; lane2 gets 0x05,0x06; lane3 gets 0x07,0x08; cur_ch back to 0.
- Backpressure: mode 0 sel=1, out_ready[1]=0, send 0x11 then 0x22 → 0x11 held, in_ready=0 for 0x22. Raise out_ready[1] → 0x22 is accepted the same cycle 0x11 drains, with no bubble cycle.
- NUM_CH=3, mode 0, sel=3 data 0xFF → in_ready=1, sel_err pulses one cycle, out_valid unchanged. Mode 1 over 6 beats at BURST_LEN=1 → cur_ch sequence 0,1,2,0,1,2.
- Mode 1, BURST_LEN=4, rr_restart asserted with the 3rd beat of channel 1 → that beat lands in lane1, and the next beat goes to lane0.
- With DEMUX_ZERO_IDLE_EN defined: write 0x5A to lane3, then drain it → lane3 reads 0x00. Without the macro, lane3 still reads 0x5A with out_valid[3]=0.
